// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier with a start/busy/done handshake.
// Each RUN cycle adds the shifted multiplicand when the multiplier LSB is set.
// The multiplicand then shifts left and the multiplier shifts right, so a
// WIDTH-bit multiply always takes exactly WIDTH iterations.
module shift_add_mult #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    sum_c;

  // Partial-product add for the current iteration; cannot overflow 2*WIDTH bits.
  always_comb begin
    sum_c = acc_q + (b_q[0] ? a_q : '0);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = PW'(multiplicand);
          b_d     = multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        acc_d  = sum_c;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last iteration: the final sum goes straight to the product register.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          prod_d  = sum_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult. A cycle-level handshake model plus a queue
// of expected products (computed with '*') is checked against the DUT.
module tb_shift_add_mult;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 2 * W;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_RUN  = 2'd1;
  localparam logic [1:0] M_DONE = 2'd2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  typedef struct {
    logic [PW-1:0] prod;
    int unsigned   acc_cyc;
  } exp_t;

  exp_t sb[$];

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;
  int unsigned cyc     = 0;
  int unsigned n_done  = 0;

  logic [1:0]    m_state = M_IDLE;
  int unsigned   m_cnt   = 0;
  logic [PW-1:0] m_prod  = '0;

  bit          chk_period    = 1'b0;
  bit          have_last     = 1'b0;
  int unsigned last_done_cyc = 0;

  shift_add_mult #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference handshake model: accept in IDLE, WIDTH RUN cycles, one DONE cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      m_prod  = '0;
      sb.delete();
    end else begin
      cyc++;
      case (m_state)
        M_IDLE: begin
          if (start) begin
            sb.push_back('{PW'(mcand) * PW'(mplier), cyc});
            m_state = M_RUN;
            m_cnt   = 0;
          end
        end
        M_RUN: begin
          if (m_cnt == W - 1) begin
            m_state = M_DONE;
            if (sb.size() > 0) m_prod = sb[0].prod;
          end else begin
            m_cnt++;
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  // Per-cycle output check and scoreboard pop on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    check("busy", 32'(busy), 32'(m_state == M_RUN));
    check("done", 32'(done), 32'(m_state == M_DONE));
    check("product_hold", 32'(product), 32'(m_prod));
    if (done) begin
      n_done++;
      check("sb_nonempty_at_done", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("product", 32'(product), 32'(e.prod));
        // DONE is entered on the WIDTH-th edge after the start edge.
        check("latency", cyc - e.acc_cyc, W);
      end
      if (chk_period && have_last) check("period", cyc - last_done_cyc, W + 2);
      last_done_cyc = cyc;
      have_last     = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    repeat (W + 2) tick();
  endtask

  initial begin
    rst_n  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic multiplies, including max and zero operands.
    run_op(8'hF0, 8'h02);
    check("t1_product", 32'(product), 32'h01E0);
    run_op(8'hFF, 8'hFF);
    check("t2_max", 32'(product), 32'hFE01);
    run_op(8'h00, 8'hA5);
    check("t2_zero", 32'(product), 32'h0000);

    // start pulses during RUN and DONE are ignored.
    n_done = 0;
    mcand  = 8'h0D;
    mplier = 8'h0B;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    mcand  = 8'h01;
    mplier = 8'h01;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    check("t3_product", 32'(product), 32'h008F);
    check("t3_one_done", n_done, 1);
    check("t3_no_restart", 32'(busy), 32'd0);

    // Continuous start: one operation every WIDTH+2 cycles.
    n_done     = 0;
    have_last  = 1'b0;
    chk_period = 1'b1;
    mcand      = 8'h03;
    mplier     = 8'h05;
    start      = 1'b1;
    repeat (35) tick();
    start      = 1'b0;
    repeat (W + 2) tick();
    chk_period = 1'b0;
    check("t4_product", 32'(product), 32'h000F);
    check("t4_done_count", n_done, 4);

    // Asynchronous reset in the middle of RUN.
    mcand  = 8'hC8;
    mplier = 8'h07;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_product", 32'(product), 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    n_done = 0;
    repeat (12) tick();
    check("t5_no_done_after_abort", n_done, 0);
    run_op(8'h07, 8'h09);
    check("t5_product", 32'(product), 32'h003F);

    // Operand inputs toggle every cycle after the start edge.
    mcand  = 8'h12;
    mplier = 8'h34;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      mcand  = W'($urandom);
      mplier = W'($urandom);
      if (i == 3) check("t6_prev_hold", 32'(product), 32'h003F);
      tick();
    end
    check("t6_product", 32'(product), 32'h03A8);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
